register_bank: RTL
==================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width, with DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning entry 0 reads as zero and ignores writes when 1.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled when 1.
REQ-005 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port RegWrite, input, 1 bit: write enable for the main array.
REQ-008 Port WriteReg, input, ADDR_W bits: write address.
REQ-009 Port WriteData, input, DATA_W bits: write data.
REQ-010 Ports ReadReg1 and ReadReg2, input, ADDR_W bits each: read addresses.
REQ-011 Ports ReadData1 and ReadData2, output, DATA_W bits each: read data.
REQ-012 Port register_v0, output, DATA_W bits: continuous view of entry 2, post-bypass.
REQ-013 Port HiLoWrite, input, 1 bit: write enable for the HI/LO pair.
REQ-014 Ports HiIn and LoIn, input, DATA_W bits each: HI/LO write data.
REQ-015 Ports Hi and Lo, output, DATA_W bits each: registered HI/LO contents.
REQ-016 Port busy, output, 1 bit: registered flag, 1 while the clear sequencer runs.

Function
REQ-017 The FSM SHALL have two states: READY and CLEAR, plus an ADDR_W-bit clear index clr_idx.
REQ-018 In CLEAR, each cycle SHALL write zero to entry clr_idx and increment clr_idx.
REQ-019 When clr_idx = DEPTH-1 in CLEAR, that entry SHALL be cleared, the state SHALL go to READY, and busy SHALL go to 0 on the same edge.
REQ-020 While busy=1, RegWrite and HiLoWrite SHALL be ignored.
REQ-021 While busy=1, ReadData1, ReadData2 and register_v0 SHALL output zero regardless of array contents.
REQ-022 In READY, with RegWrite=1, the rising edge SHALL store WriteData at WriteReg, except when ZERO_REG=1 and WriteReg=0, where the write SHALL be discarded.
REQ-023 Reads SHALL be combinational from the array.
REQ-024 When ZERO_REG=1, address 0 SHALL always read as zero, including under bypass.
REQ-025 When BYPASS=1, READY, RegWrite=1, and ReadRegN = WriteReg (non-zero-gated), ReadDataN SHALL equal WriteData in the same cycle; register_v0 SHALL behave the same way for WriteReg=2.
REQ-026 When BYPASS=0, reads SHALL return the pre-edge array contents.
REQ-027 Both read ports SHALL serve the same address simultaneously with identical results.
REQ-028 In READY, HiLoWrite=1 SHALL load HiIn and LoIn into Hi and Lo on the rising edge; HI/LO SHALL NOT be bypassed.
REQ-029 RegWrite and HiLoWrite asserted in the same cycle SHALL both take effect.
REQ-030 clr_idx SHALL NOT wrap back into CLEAR; exit is solely via REQ-019.

Reset
REQ-031 When reset=1 at a rising edge, the state SHALL go to CLEAR, clr_idx to 0, busy to 1, and Hi and Lo to 0.
REQ-032 While reset stays high, clr_idx SHALL be held at 0 and no entry SHALL be cleared beyond entry 0.
REQ-033 Sweep timing: with ADDR_W=5, busy SHALL fall exactly 32 edges after the first edge with reset=0.
REQ-034 Reset asserted mid-CLEAR SHALL restart the sweep at index 0.
REQ-035 Reset SHALL take priority over all writes in the same cycle.
REQ-036 Array contents before the first reset are undefined but masked by busy.

Verification
REQ-037 Reset sweep: pulse reset for 1 cycle (ADDR_W=5). Required: busy=1 for 32 cycles, then 0; all 32 entries read 0; Hi=Lo=0.
REQ-038 Write/read: write 0xDEADBEEF to r5. Required: next cycle ReadData1 (ReadReg1=5) = 0xDEADBEEF; same cycle with BYPASS=1 also = 0xDEADBEEF; with BYPASS=0, old value.
REQ-039 Zero register: write 0x12345678 to r0. Required: ReadData1 and ReadData2 at address 0 = 0 in the same cycle and afterwards.
REQ-040 register_v0: write 0x0000002A to r2. Required: register_v0 = 0x2A (same cycle with bypass); Hi/Lo unchanged.
REQ-041 Busy gating: assert RegWrite (r7 = 0xFFFFFFFF) and HiLoWrite (1/2) during cycle 10 of the sweep. Required: after the sweep, r7 = 0, Hi = 0, Lo = 0.
REQ-042 Reset mid-sweep: reassert reset at sweep cycle 20. Required: busy stays 1 for a further 32 cycles after deassertion; simultaneous HiLoWrite (HiIn=3, LoIn=4) and RegWrite in READY update both.

Source files
------------

// File: rtl/register_bank.sv
// Register file with optional zero register and write-to-read forwarding,
// a HI/LO pair, and a post-reset sequencer that zeroes every entry.
module register_bank #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic [DATA_W-1:0] register_v0,
    input  logic              HiLoWrite,
    input  logic [DATA_W-1:0] HiIn,
    input  logic [DATA_W-1:0] LoIn,
    output logic [DATA_W-1:0] Hi,
    output logic [DATA_W-1:0] Lo,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        READY,
        CLEAR
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_idx, clr_idx_next;
    logic              busy_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              hilo_en;
    logic [DATA_W-1:0] mem [DEPTH];

    // The sweep shares the array write port, so user writes are naturally locked out.
    always_comb begin
        state_next   = state;
        clr_idx_next = clr_idx;
        busy_next    = busy;
        wr_en        = 1'b0;
        wr_addr      = WriteReg;
        wr_data      = WriteData;
        hilo_en      = 1'b0;
        if (reset) begin
            state_next   = CLEAR;
            clr_idx_next = '0;
            busy_next    = 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en   = 1'b1;
                    wr_addr = clr_idx;
                    wr_data = '0;
                    if (&clr_idx) begin
                        state_next = READY;
                        busy_next  = 1'b0;
                    end else begin
                        clr_idx_next = clr_idx + 1'b1;
                    end
                end
                default: begin
                    wr_en   = RegWrite && !((ZERO_REG != 0) && (WriteReg == '0));
                    hilo_en = HiLoWrite;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state   <= state_next;
        clr_idx <= clr_idx_next;
        busy    <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (hilo_en) begin
            Hi <= HiIn;
            Lo <= LoIn;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] a);
        if (busy)
            return '0;
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        if ((BYPASS != 0) && (state == READY) && RegWrite && (a == WriteReg))
            return WriteData;
        return mem[a];
    endfunction

    always_comb ReadData1   = read_port(ReadReg1);
    always_comb ReadData2   = read_port(ReadReg2);
    always_comb register_v0 = read_port(ADDR_W'(2));

endmodule
